// File: rtl/cs161_trace_buffer.sv
// Retirement trace capture FIFO with run-control FSM for the cs161 datapath.
// Optional PC trigger (ARMED state) compiled in with `define TRACE_TRIGGER_EN.
module cs161_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [31:0]   prog_count,
  input  logic [5:0]    instr_opcode,
  input  logic          reg_write,
  input  logic [4:0]    write_reg_addr,
  input  logic [31:0]   write_reg_data,
  input  logic [31:0]   trig_pc,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [31:0]   rd_pc,
  output logic [5:0]    rd_opcode,
  output logic          rd_wen,
  output logic [4:0]    rd_waddr,
  output logic [31:0]   rd_wdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic [7:0]    drop_count,
  output logic [1:0]    state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } st_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rec_t;

  st_t           st;
  rec_t          mem [DEPTH];
  rec_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [7:0]    drops;
  logic          match;
  logic          rec;
  logic          pop;
  logic          push;

`ifdef TRACE_TRIGGER_EN
  localparam st_t START_ST = ARMED;
  assign match = (prog_count == trig_pc);
`else
  localparam st_t START_ST = RUN;
  logic unused_trig;
  assign unused_trig = ^trig_pc;
  assign match = 1'b0;
`endif

  assign full     = (cnt == CW'(DEPTH));
  assign rd_valid = (cnt != '0);
  assign pop      = rd_valid & rd_ready;
  assign rec      = !stop && (st == RUN || (st == ARMED && match));
  // A full FIFO still takes the record when the head leaves this cycle.
  assign push     = rec && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= IDLE;
      drops <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (start && !stop) begin
            st    <= START_ST;
            drops <= '0;
          end
        end
        ARMED: begin
          if (stop)       st <= IDLE;
          else if (match) st <= RUN;
        end
        RUN: begin
          if (stop) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
      if (rec && !push && drops != 8'hFF)
        drops <= drops + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{pc:    prog_count,
                       op:    instr_opcode,
                       wen:   reg_write,
                       waddr: write_reg_addr,
                       wdata: write_reg_data};
  end

  // Head is forced to zero while empty so reset shows clean outputs.
  assign head       = rd_valid ? mem[rd_ptr] : '0;
  assign rd_pc      = head.pc;
  assign rd_opcode  = head.op;
  assign rd_wen     = head.wen;
  assign rd_waddr   = head.waddr;
  assign rd_wdata   = head.wdata;
  assign count      = cnt;
  assign drop_count = drops;
  assign state      = st;

endmodule

// File: tb/tb_cs161_trace_buffer.sv
// Self-checking bench for cs161_trace_buffer: vector table, corner
// sequences and a queue-based reference model under random stimulus.
module tb_cs161_trace_buffer;

  localparam int DEPTH = 16;
  localparam int CW    = 5;
`ifdef TRACE_TRIGGER_EN
  localparam int ARM_ST = 1;
  localparam bit TRIG   = 1'b1;
`else
  localparam int ARM_ST = 2;
  localparam bit TRIG   = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [31:0]   prog_count;
  logic [5:0]    instr_opcode;
  logic          reg_write;
  logic [4:0]    write_reg_addr;
  logic [31:0]   write_reg_data;
  logic [31:0]   trig_pc;
  logic          rd_valid;
  logic          rd_ready;
  logic [31:0]   rd_pc;
  logic [5:0]    rd_opcode;
  logic          rd_wen;
  logic [4:0]    rd_waddr;
  logic [31:0]   rd_wdata;
  logic [CW-1:0] count;
  logic          full;
  logic [7:0]    drop_count;
  logic [1:0]    state;

  cs161_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .prog_count(prog_count), .instr_opcode(instr_opcode),
    .reg_write(reg_write), .write_reg_addr(write_reg_addr),
    .write_reg_data(write_reg_data), .trig_pc(trig_pc),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc),
    .rd_opcode(rd_opcode), .rd_wen(rd_wen), .rd_waddr(rd_waddr),
    .rd_wdata(rd_wdata), .count(count), .full(full),
    .drop_count(drop_count), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] pc);
    prog_count     = pc;
    instr_opcode   = pc[7:2];
    reg_write      = pc[2];
    write_reg_addr = pc[6:2];
    write_reg_data = pc ^ 32'hA5A5_0000;
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; stop = 1'b0; rd_ready = 1'b0;
    trig_pc = '0;
    set_pc('0);
    tick;
    rst = 1'b0;
  endtask

  // Reference model: queue of records plus abstract run state.
  typedef struct {
    logic [31:0] pc;
    logic [5:0]  op;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
  } mrec_t;
  mrec_t q[$];
  int    m_state;
  int    m_drop;

  task automatic model_step;
    bit    pop;
    bit    hit;
    bit    rec;
    bit    acc;
    int    ns;
    mrec_t r;
    pop = (q.size() > 0) && rd_ready;
    hit = TRIG && (prog_count == trig_pc);
    rec = !stop && (m_state == 2 || (m_state == 1 && hit));
    acc = rec && (q.size() < DEPTH || pop);
    ns  = m_state;
    if (stop) ns = 0;
    else if (m_state == 0 && start) begin
      ns = ARM_ST;
      m_drop = 0;
    end else if (m_state == 1 && hit) ns = 2;
    if (pop) void'(q.pop_front());
    if (acc) begin
      r.pc = prog_count; r.op = instr_opcode; r.wen = reg_write;
      r.wa = write_reg_addr; r.wd = write_reg_data;
      q.push_back(r);
    end else if (rec && m_drop < 255) m_drop++;
    m_state = ns;
  endtask

  task automatic model_check;
    chk("m_count", 32'(count), 32'(q.size()));
    chk("m_valid", 32'(rd_valid), 32'(q.size() > 0));
    chk("m_full", 32'(full), 32'(q.size() == DEPTH));
    chk("m_state", 32'(state), 32'(m_state));
    chk("m_drop", 32'(drop_count), 32'(m_drop));
    if (q.size() > 0) begin
      chk("m_pc", rd_pc, q[0].pc);
      chk("m_op", 32'(rd_opcode), 32'(q[0].op));
      chk("m_wen", 32'(rd_wen), 32'(q[0].wen));
      chk("m_wa", 32'(rd_waddr), 32'(q[0].wa));
      chk("m_wd", rd_wdata, q[0].wd);
    end
  endtask

  typedef struct {
    logic        st;
    logic        sp;
    logic        rdy;
    logic [31:0] pc;
    int          e_cnt;
    logic        e_val;
    int          e_state;
    logic [31:0] e_pc;
  } vec_t;
  vec_t tbl[11];

  logic [31:0] exp_pc[$];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,   0, 1'b0, ARM_ST, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1, 1'b1, 2, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h4,   2, 1'b1, 2, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h8,   3, 1'b1, 2, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'hC,   4, 1'b1, 2, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h100, 4, 1'b1, 0, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h104, 3, 1'b1, 0, 32'h4};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h108, 2, 1'b1, 0, 32'h8};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h10C, 1, 1'b1, 0, 32'hC};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h110, 0, 1'b0, 0, 32'h0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h114, 0, 1'b0, 0, 32'h0};

    // Reset state
    rst = 1'b1; start = 1'b0; stop = 1'b0; rd_ready = 1'b0;
    trig_pc = '0;
    set_pc('0);
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_pc", rd_pc, 0);
    tick;
    rst = 1'b0;

    // Basic capture and drain, stop drops the coincident record
    for (int i = 0; i < 11; i++) begin
      start = tbl[i].st; stop = tbl[i].sp; rd_ready = tbl[i].rdy;
      set_pc(tbl[i].pc);
      tick;
      chk($sformatf("t%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("t%0d_valid", i), 32'(rd_valid), 32'(tbl[i].e_val));
      chk($sformatf("t%0d_state", i), 32'(state), 32'(tbl[i].e_state));
      if (tbl[i].e_val)
        chk($sformatf("t%0d_pc", i), rd_pc, tbl[i].e_pc);
    end
    start = 1'b0; stop = 1'b0; rd_ready = 1'b0;

    // Overflow, then full with simultaneous read and write
    do_reset;
    trig_pc = 32'h200;
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_pc(32'h200 + 32'(4 * i));
      tick;
    end
    chk("ovf_full", 32'(full), 1);
    chk("ovf_count", 32'(count), 16);
    chk("ovf_drop", 32'(drop_count), 4);
    chk("ovf_head", rd_pc, 32'h200);
    rd_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      set_pc(32'h300 + 32'(4 * j));
      tick;
    end
    rd_ready = 1'b0;
    chk("rw_count", 32'(count), 16);
    chk("rw_drop", 32'(drop_count), 4);
    stop = 1'b1; set_pc(32'h400); tick; stop = 1'b0;
    chk("rw_state", 32'(state), 0);
    chk("rw_count2", 32'(count), 16);
    exp_pc.delete();
    for (int i = 3; i < 16; i++) exp_pc.push_back(32'h200 + 32'(4 * i));
    for (int j = 0; j < 3; j++) exp_pc.push_back(32'h300 + 32'(4 * j));
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d_valid", k), 32'(rd_valid), 1);
      chk($sformatf("drain%0d_pc", k), rd_pc, exp_pc[k]);
      rd_ready = 1'b1; tick; rd_ready = 1'b0;
    end
    chk("drain_valid", 32'(rd_valid), 0);
    chk("drain_count", 32'(count), 0);

    // PC trigger (or direct RUN when the trigger is not built)
    do_reset;
    trig_pc = 32'h10;
    start = 1'b1; tick; start = 1'b0;
    chk("trg_state0", 32'(state), 32'(ARM_ST));
    for (int i = 0; i < 8; i++) begin
      set_pc(32'(4 * i));
      tick;
      if (TRIG && i < 4) begin
        chk($sformatf("trg%0d_state", i), 32'(state), 1);
        chk($sformatf("trg%0d_count", i), 32'(count), 0);
      end
    end
    chk("trg_state", 32'(state), 2);
    chk("trg_first", rd_pc, TRIG ? 32'h10 : 32'h0);
    chk("trg_count", 32'(count), TRIG ? 4 : 8);

    // Asynchronous reset mid-capture
    do_reset;
    trig_pc = 32'h0;
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_pc(32'(4 * i));
      tick;
    end
    chk("ar_count5", 32'(count), 5);
    #2 rst = 1'b1;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_valid", 32'(rd_valid), 0);
    chk("ar_state", 32'(state), 0);
    tick;
    rst = 1'b0;

    // Randomized traffic against the reference model
    do_reset;
    trig_pc = 32'h10;
    q.delete(); m_state = 0; m_drop = 0;
    for (int c = 0; c < 3000; c++) begin
      start    = ($urandom_range(0, 9) == 0);
      stop     = ($urandom_range(0, 24) == 0);
      rd_ready = ($urandom_range(0, 2) == 0);
      prog_count     = 32'($urandom_range(0, 15)) << 2;
      instr_opcode   = 6'($urandom);
      reg_write      = 1'($urandom);
      write_reg_addr = 5'($urandom);
      write_reg_data = $urandom;
      model_step;
      tick;
      model_check;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cs161_trace_buffer.md
# cs161_trace_buffer

Debug trace capture stage that sits directly downstream of the cs161 single-cycle datapath and consumes its per-instruction debug outputs. Each cycle it can record one retirement record: program counter, opcode, register write address, write data and write enable. Records go into a DEPTH-entry FIFO that a testbench or debug host drains through a valid/ready read port. A small run-control FSM gates capture, and an optional PC trigger is compiled in by macro.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥ 2.
- CW, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; arms or starts capture.
- stop  in  1  one-cycle pulse; ends capture.
- prog_count  in  32  datapath PC of the instruction retiring this cycle.
- instr_opcode  in  6  instruction[31:26].
- reg_write  in  1  datapath register write enable.
- write_reg_addr  in  5  destination register.
- write_reg_data  in  32  register write data.
- trig_pc  in  32  trigger PC; used only with TRACE_TRIGGER_EN.
- rd_valid  out  1  head entry available.
- rd_ready  in  1  consumer accepts the head entry.
- rd_pc  out  32  head entry PC.
- rd_opcode  out  6  head entry opcode.
- rd_wen  out  1  head entry reg_write.
- rd_waddr  out  5  head entry write address.
- rd_wdata  out  32  head entry write data.
- count  out  CW  number of stored entries.
- full  out  1  count == DEPTH.
- drop_count  out  8  records lost to a full FIFO; saturates at 255.
- state  out  2  run state: IDLE=0, ARMED=1, RUN=2.

## Operation
- Record = {prog_count, instr_opcode, reg_write, write_reg_addr, write_reg_data}, 76 bits.
- FSM:
  - IDLE → start → ARMED when TRACE_TRIGGER_EN is defined; otherwise IDLE → start → RUN.
  - ARMED → (prog_count == trig_pc) → RUN. The matching cycle is itself recorded.
  - RUN → stop → IDLE.
  - ARMED → stop → IDLE.
  - start while in ARMED or RUN is ignored.
  - start and stop in the same cycle: stop wins; the state goes to, or stays in, IDLE.
- Write condition, evaluated each cycle:
  - rec = (state == RUN && !stop) || (state == ARMED && match && !stop).
  - rec is accepted when !full, or when full and a read handshake occurs in the same cycle.
  - Otherwise the record is dropped and drop_count increments (saturating).
- start, when accepted from IDLE, clears drop_count to 0. FIFO contents are retained.
- Read: rd_valid = (count != 0). A handshake is rd_valid && rd_ready; it pops the head entry. rd_ready while empty has no effect.
- rd_* present the head entry. Their value is don't-care when rd_valid = 0.
- Pointers: wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
- count update: +1 on write only, −1 on read only, unchanged on simultaneous read and write.

## Timing
- Reset, asynchronous: state = IDLE, count = 0, full = 0, rd_valid = 0, drop_count = 0, pointers = 0. rd_* outputs = 0.
- A record sampled on edge N is visible on rd_* with rd_valid = 1 after edge N (1-cycle latency) when the FIFO was empty.
- A pop on edge N presents the next entry after edge N. count, full and rd_valid update on the same edge.
- Back-to-back: one write and one read per cycle sustain indefinitely at DEPTH ≥ 2.
- Reset mid-capture discards all entries and returns to IDLE immediately, without waiting for a clock.
- No combinational path from rd_ready to any output other than through registers. rd_valid and count are register-derived.

## Configuration
- TRACE_TRIGGER_EN:
  - Defined: the ARMED state and the trig_pc compare (32-bit equality) are present.
  - Undefined: trig_pc is unused, ARMED is never entered, and start goes directly to RUN. state never reads 1.

## Test plan
- Reset, then start, then 4 cycles with PC 0x0, 0x4, 0x8, 0xC, then stop, with rd_ready = 0 → count = 4. Draining gives rd_pc 0x0, 0x4, 0x8, 0xC in order, and rd_valid drops after the 4th pop.
- Overflow with DEPTH = 16: RUN for 20 cycles with rd_ready = 0 → full = 1, count = 16, drop_count = 4. The stored PCs are the first 16 values.
- Full with simultaneous read and write: hold full, assert rd_ready for 3 cycles while in RUN → count stays 16, drop_count unchanged, no lost records.
- start and stop in the same cycle from IDLE → state stays 0 and count stays 0. stop while RUN with a record present that cycle → that record is not written.
- TRACE_TRIGGER_EN defined, trig_pc = 0x10, PC stepping by 4 from 0x0 → state = 1 until PC 0x10, first stored rd_pc = 0x10, state = 2 afterwards. Undefined: first stored rd_pc = 0x0.
- Assert rst mid-RUN with count = 5 → count, rd_valid and state are 0 before the next clk edge.
